shift_tx: RTL
=============

Name: shift_tx

Overview:
- Parallel-in, serial-out transmitter that drives the serial input and mode of a downstream shift-register receiver. That receiver uses mode 2 to shift left with D entering at the LSB, and mode 3 to shift right with D entering at the MSB.
- Accepts a W-bit word on a ready/valid load handshake and emits it one bit per clock, together with the matching receiver mode code.
- After W cycles, the receiver's parallel output equals the word that was loaded.
- Sits between the parallel data producer and the serial link.

Parameters:
- W, 8, data word width in bits (W >= 2).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- par_i  input  W  word to transmit; sampled on accept.
- load_i  input  1  load request (valid).
- dir_i  input  1  0 = MSB-first (receiver left shift, mode 2); 1 = LSB-first (receiver right shift, mode 3); sampled on accept.
- ready_o  output  1  transmitter can accept a word this cycle.
- D_o  output  1  serial data bit to the receiver's D input.
- mode_o  output  2  mode code to the receiver's mode_i: 0 = hold, 2 = left shift, 3 = right shift; never 1.
- done_o  output  1  one-cycle pulse after the final bit of a frame.
- par_valid_o  output  1  parity bit is on D_o (optional feature only; otherwise constant 0).

Behaviour:
- Reset (async, rst=1): state IDLE; ready_o=1, D_o=0, mode_o=0, done_o=0, par_valid_o=0; shift and count registers cleared. Any in-flight frame is discarded immediately, with no done_o pulse.
- All outputs are registered; no combinational path from inputs to outputs except ready_o, which is decoded from state only.
- States:
  - IDLE: ready_o=1, mode_o=0, D_o=0.
  - SEND: ready_o=0.
  - PAR: ready_o=0; exists only with the optional feature.
- Accept: a rising edge with load_i=1 and ready_o=1 captures par_i and dir_i, loads the bit counter with W-1, and moves to SEND.
- SEND, one bit per cycle for exactly W cycles:
  - Starting from the cycle after accept, D_o carries the next bit and mode_o = (dir ? 3 : 2).
  - dir=0 sends bit W-1 first, down to bit 0. dir=1 sends bit 0 first, up to bit W-1.
  - Each edge shifts the internal register and decrements the counter.
  - When the counter is 0 on an edge: go to IDLE (or PAR if the feature is enabled), set mode_o=0 and D_o=0, and assert done_o for exactly that following cycle.
- load_i while ready_o=0 is ignored; the word is not queued and the producer must hold it.
- par_i and dir_i changing mid-frame have no effect.
- Back-to-back:
  - In the done_o cycle the state is IDLE, so ready_o=1 and a new load is accepted on that edge.
  - The minimum frame period is W+1 cycles, with one mode_o=0 gap between frames.
- Latency: first bit appears 1 cycle after accept. At the end of the last SEND cycle the receiver holds the word; done_o is high in the cycle after the last bit.
- Counter width: $clog2(W). The counter never wraps, because it is loaded only on accept.

Optional Feature:
- Macro: SHIFT_TX_PARITY_EN.
- Enabled:
  - After the last data bit, the FSM enters PAR for one cycle: D_o = even parity (XOR of all W data bits), mode_o=0 (receiver holds, word is not disturbed), par_valid_o=1.
  - Then the FSM returns to IDLE with done_o=1 in that following cycle.
  - Minimum frame period becomes W+2 cycles.
  - Reset during PAR drops it immediately.
- Disabled: no PAR state; par_valid_o is tied to 0; timing is as described above.

Test Plan:
- Reset: assert rst mid-cycle with load_i=1 → immediately ready_o=1, mode_o=0, D_o=0, done_o=0; the values hold across clocks while rst=1.
- MSB-first: par_i=8'hA5, dir_i=0, one-cycle load → D_o = 1,0,1,0,0,1,0,1 on the next 8 cycles with mode_o=2 and ready_o=0; then done_o=1 for one cycle, mode_o=0, ready_o=1.
- LSB-first: par_i=8'h07, dir_i=1 → D_o = 1,1,1,0,0,0,0,0 with mode_o=3 for 8 cycles; done_o pulses once.
- Loopback with the shift-register receiver (nrst driven by ~rst): load 8'hA5 dir 0, then 8'h3C dir 1 in the done cycle → receiver P = 8'hA5 at the first done_o and 8'h3C at the second; exactly one mode_o=0 cycle between frames.
- Busy/abort: load 8'hFF, pulse load_i=1 with 8'h00 during cycle 3 → ignored, 8 ones sent. A second frame with rst pulsed at bit 4 → outputs return to reset values within the reset cycle, no done_o pulse, and the next load sends a full frame.
- Parity (SHIFT_TX_PARITY_EN defined): 8'hA5 → 9th cycle D_o=0, par_valid_o=1, mode_o=0. 8'h07 → D_o=1. done_o follows in the 10th cycle.

Source files
------------

// File: rtl/shift_tx_if.sv
// Load handshake and serial-link signals between a word producer and shift_tx.
// The slave modport is the transmitter; the master modport is the producer/link side.
interface shift_tx_if #(
  parameter int W = 8
);
  // Handshake: a word transfers on a rising edge where load_i and ready_o are both 1.
  // ready_o depends only on transmitter state. A producer that sees ready_o=0 must
  // hold par_i/dir_i and keep load_i asserted until the transfer happens.
  logic [W-1:0] par_i;
  logic         load_i;
  logic         dir_i;
  logic         ready_o;
  logic         D_o;
  logic [1:0]   mode_o;
  logic         done_o;
  logic         par_valid_o;
  logic [1:0]   state_o;

  modport slave (
    input  par_i, load_i, dir_i,
    output ready_o, D_o, mode_o, done_o, par_valid_o, state_o
  );

  modport master (
    output par_i, load_i, dir_i,
    input  ready_o, D_o, mode_o, done_o, par_valid_o, state_o
  );
endinterface

// File: rtl/shift_tx.sv
// Parallel-in/serial-out transmitter feeding a mode-controlled shift-register receiver.
// Define SHIFT_TX_PARITY_EN to append one even-parity cycle (PAR) after each frame.
module shift_tx #(
  parameter int W = 8
) (
  input  logic       clk,
  input  logic       rst,
  shift_tx_if.slave  bus
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
`ifdef SHIFT_TX_PARITY_EN
    , PAR = 2'd2
`endif
  } state_t;

  state_t        state_q;
  logic [W-1:0]  shreg_q;
  logic [CW-1:0] cnt_q;
  logic          dir_q;
  logic          d_q;
  logic [1:0]    mode_q;
  logic          done_q;
`ifdef SHIFT_TX_PARITY_EN
  logic          parity_q;
  logic          parv_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      d_q      <= 1'b0;
      mode_q   <= 2'd0;
      done_q   <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
      parity_q <= 1'b0;
      parv_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          d_q    <= 1'b0;
          mode_q <= 2'd0;
          if (bus.load_i) begin
            // The first bit goes straight to D; the register keeps the remainder.
            state_q <= SEND;
            dir_q   <= bus.dir_i;
            cnt_q   <= CW'(W - 1);
            if (bus.dir_i) begin
              d_q     <= bus.par_i[0];
              shreg_q <= bus.par_i >> 1;
              mode_q  <= 2'd3;
            end else begin
              d_q     <= bus.par_i[W-1];
              shreg_q <= bus.par_i << 1;
              mode_q  <= 2'd2;
            end
`ifdef SHIFT_TX_PARITY_EN
            parity_q <= ^bus.par_i;
`endif
          end
        end
        SEND: begin
          if (cnt_q == '0) begin
            mode_q <= 2'd0;
`ifdef SHIFT_TX_PARITY_EN
            state_q <= PAR;
            d_q     <= parity_q;
            parv_q  <= 1'b1;
`else
            state_q <= IDLE;
            d_q     <= 1'b0;
            done_q  <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q - CW'(1);
            if (dir_q) begin
              d_q     <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
            end else begin
              d_q     <= shreg_q[W-1];
              shreg_q <= shreg_q << 1;
            end
          end
        end
`ifdef SHIFT_TX_PARITY_EN
        PAR: begin
          state_q <= IDLE;
          d_q     <= 1'b0;
          parv_q  <= 1'b0;
          done_q  <= 1'b1;
        end
`endif
        default: begin
          state_q <= IDLE;
          d_q     <= 1'b0;
          mode_q  <= 2'd0;
        end
      endcase
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.D_o     = d_q;
  assign bus.mode_o  = mode_q;
  assign bus.done_o  = done_q;
  assign bus.state_o = state_q;
`ifdef SHIFT_TX_PARITY_EN
  assign bus.par_valid_o = parv_q;
`else
  assign bus.par_valid_o = 1'b0;
`endif
endmodule
